// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised single-clock FIFO: pointer width
// helper and the bit positions of the sticky error flags.
package sync_fifo_pkg;

  localparam int ERR_OVF  = 0;
  localparam int ERR_UNF  = 1;
  localparam int ERR_BITS = 2;

  // Pointers carry one extra wrap bit above the memory address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port and one
// asynchronous read port; no reset so contents survive flush.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with registered occupancy flags, count,
// sticky overflow/underflow, flush and optional first-word-fall-through.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  signal_write,
  input  logic                  signal_read,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t FULL_XOR = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam ptr_t AF_LVL   = ptr_t'(AFULL_THRESH);
  localparam ptr_t AE_LVL   = ptr_t'(AEMPTY_THRESH);

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic afull_q, afull_d;
  logic aempty_q, aempty_d;
  logic [ERR_BITS-1:0] err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic wr_ok, rd_ok, mem_we;
  logic ovf_ev, unf_ev;

  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (write_data),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    // A read on empty is never accepted; a write into a full FIFO is
    // accepted only when a read frees a slot in the same cycle.
    rd_ok  = signal_read & ~empty_q;
    wr_ok  = signal_write & (~full_q | rd_ok);
    mem_we = wr_ok & ~flush;
    ovf_ev = signal_write & ~wr_ok & ~flush;
    unf_ev = signal_read & empty_q & ~flush;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + ptr_t'(wr_ok);
      rptr_d  = rptr_q + ptr_t'(rd_ok);
      count_d = count_q + ptr_t'(wr_ok) - ptr_t'(rd_ok);
    end

    full_d   = (wptr_d ^ rptr_d) == FULL_XOR;
    empty_d  = (wptr_d == rptr_d);
    afull_d  = (count_d >= AF_LVL);
    aempty_d = (count_d <= AE_LVL);

    // A new error event beats a coincident clear.
    err_d          = err_q;
    err_d[ERR_OVF] = (err_q[ERR_OVF] & ~clear_err) | ovf_ev;
    err_d[ERR_UNF] = (err_q[ERR_UNF] & ~clear_err) | unf_ev;

    rdata_d = rdata_q;
    if (FWFT) begin
      if (!empty_q) rdata_d = mem_rdata;
    end else begin
      if (rd_ok && !flush) rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // In FWFT mode the head word is shown live; rdata_q holds it once empty.
  assign read_data    = (FWFT && !empty_q) ? mem_rdata : rdata_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = err_q[ERR_OVF];
  assign underflow    = err_q[ERR_UNF];

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one standard-mode and one FWFT instance,
// driven by a linear step sequence with hand-computed expectations.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Standard-mode instance signals
  logic [7:0] write_data = '0;
  logic signal_write = 1'b0, signal_read = 1'b0, flush = 1'b0, clear_err = 1'b0;
  logic [7:0] read_data;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  // FWFT instance signals
  logic [7:0] f_write_data = '0;
  logic f_signal_write = 1'b0, f_signal_read = 1'b0, f_flush = 1'b0, f_clear_err = 1'b0;
  logic [7:0] f_read_data;
  logic f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0] f_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .write_data(write_data), .signal_write(signal_write),
    .signal_read(signal_read), .flush(flush), .clear_err(clear_err),
    .read_data(read_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .write_data(f_write_data), .signal_write(f_signal_write),
    .signal_read(f_signal_read), .flush(f_flush), .clear_err(f_clear_err),
    .read_data(f_read_data), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
    .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_rdata", 32'(read_data), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_count", 32'(count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    check("rst_f_empty", 32'(f_empty), 1);
    check("rst_f_rdata", 32'(f_read_data), 0);

    // Read on empty
    signal_read = 1'b1;
    step();
    signal_read = 1'b0;
    check("rde_unf", 32'(underflow), 1);
    check("rde_empty", 32'(empty), 1);
    check("rde_count", 32'(count), 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("clr_unf", 32'(underflow), 0);

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      write_data = 8'(i);
      signal_write = 1'b1;
      step();
      check("fill_count", 32'(count), 32'(i));
      check("fill_full", 32'(full), (i == 8) ? 1 : 0);
      check("fill_afull", 32'(almost_full), (i >= 6) ? 1 : 0);
      check("fill_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
      check("fill_empty", 32'(empty), 0);
    end

    // Ninth write rejected
    write_data = 8'd9;
    step();
    signal_write = 1'b0;
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(count), 8);
    check("ovf_full", 32'(full), 1);

    // Full with write+read: both accepted
    signal_write = 1'b1;
    signal_read = 1'b1;
    write_data = 8'd9;
    step();
    signal_write = 1'b0;
    signal_read = 1'b0;
    check("fwr_rdata", 32'(read_data), 1);
    check("fwr_count", 32'(count), 8);
    check("fwr_full", 32'(full), 1);

    // Drain 2..9
    for (int i = 2; i <= 9; i++) begin
      signal_read = 1'b1;
      step();
      check("drain_rdata", 32'(read_data), 32'(i));
      check("drain_count", 32'(count), 32'(9 - i));
      check("drain_full", 32'(full), 0);
    end
    signal_read = 1'b0;
    check("drain_empty", 32'(empty), 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("clr_ovf", 32'(overflow), 0);

    // Interleaved write/read pairs, pointers wrap
    for (int v = 10; v <= 29; v++) begin
      write_data = 8'(v);
      signal_write = 1'b1;
      step();
      signal_write = 1'b0;
      check("il_empty_w", 32'(empty), 0);
      check("il_count_w", 32'(count), 1);
      signal_read = 1'b1;
      step();
      signal_read = 1'b0;
      check("il_rdata", 32'(read_data), 32'(v));
      check("il_empty_r", 32'(empty), 1);
    end

    // Write+read on empty: write taken, read rejected
    write_data = 8'h33;
    signal_write = 1'b1;
    signal_read = 1'b1;
    step();
    signal_write = 1'b0;
    signal_read = 1'b0;
    check("ewr_count", 32'(count), 1);
    check("ewr_unf", 32'(underflow), 1);
    check("ewr_empty", 32'(empty), 0);
    check("ewr_rdata_hold", 32'(read_data), 29);
    signal_read = 1'b1;
    step();
    signal_read = 1'b0;
    check("ewr_rdata", 32'(read_data), 8'h33);

    // Error beats a coincident clear
    clear_err = 1'b1;
    signal_read = 1'b1;
    step();
    clear_err = 1'b0;
    signal_read = 1'b0;
    check("clr_vs_err", 32'(underflow), 1);

    // Fill to 5, then flush with a simultaneous write
    for (int i = 0; i < 5; i++) begin
      write_data = 8'(8'h40 + i);
      signal_write = 1'b1;
      step();
    end
    signal_write = 1'b0;
    check("pre_flush_count", 32'(count), 5);
    flush = 1'b1;
    signal_write = 1'b1;
    write_data = 8'h77;
    step();
    flush = 1'b0;
    signal_write = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_empty", 32'(empty), 1);
    check("flush_aempty", 32'(almost_empty), 1);
    check("flush_afull", 32'(almost_full), 0);
    check("flush_full", 32'(full), 0);
    check("flush_ovf", 32'(overflow), 0);
    check("flush_unf", 32'(underflow), 1);
    write_data = 8'h55;
    signal_write = 1'b1;
    step();
    signal_write = 1'b0;
    check("post_flush_count", 32'(count), 1);
    signal_read = 1'b1;
    step();
    signal_read = 1'b0;
    check("post_flush_rdata", 32'(read_data), 8'h55);

    // Reset mid-operation discards contents
    write_data = 8'h66;
    signal_write = 1'b1;
    step();
    step();
    signal_write = 1'b0;
    check("pre_rst_count", 32'(count), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_empty", 32'(empty), 1);
    check("mid_rst_rdata", 32'(read_data), 0);
    check("mid_rst_unf", 32'(underflow), 0);

    // FWFT: head visible after the write edge
    f_write_data = 8'hA5;
    f_signal_write = 1'b1;
    step();
    f_signal_write = 1'b0;
    check("fwft_rdata", 32'(f_read_data), 8'hA5);
    check("fwft_empty", 32'(f_empty), 0);
    check("fwft_count", 32'(f_count), 1);
    f_signal_read = 1'b1;
    step();
    f_signal_read = 1'b0;
    check("fwft_rd_empty", 32'(f_empty), 1);
    check("fwft_rd_hold", 32'(f_read_data), 8'hA5);
    f_write_data = 8'h5A;
    f_signal_write = 1'b1;
    step();
    f_write_data = 8'hC3;
    step();
    f_signal_write = 1'b0;
    check("fwft_head2", 32'(f_read_data), 8'h5A);
    check("fwft_count2", 32'(f_count), 2);
    f_signal_read = 1'b1;
    step();
    f_signal_read = 1'b0;
    check("fwft_head3", 32'(f_read_data), 8'hC3);
    check("fwft_count3", 32'(f_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
